// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the CPU register file: clear-engine state encoding and default geometry.
package cpu_regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NUM_RD = 2;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/multi_port_regfile_if.sv
// Register-file access bus: one byte-masked write port, NUM_RD read ports and the bulk-clear handshake.
interface multi_port_regfile_if
  import cpu_regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_RD = DEF_NUM_RD
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = WIDTH / 8;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [BW-1:0]           wr_be;
  logic [WIDTH-1:0]        wr_data;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_addr, clr_req,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_addr, clr_req,
    output rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every entry once, one per falling edge, then pulses clr_done.
module regfile_clear_fsm
  import cpu_regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we_c,
  output logic          idle_c,
  output logic [AW-1:0] clr_ptr
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_d;
  logic          busy_d;
  logic          done_d;

  // State register; the whole register file is clocked on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CLR_IDLE;
      clr_ptr  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_ptr  <= ptr_d;
      clr_busy <= busy_d;
      clr_done <= done_d;
    end
  end

  // Next-state: busy/done are registered copies of the upcoming state.
  always_comb begin
    state_d = state_q;
    ptr_d   = clr_ptr;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLR_CLEAR: begin
        busy_d = 1'b1;
        ptr_d  = clr_ptr + AW'(1);
        if (clr_ptr == AW'(DEPTH - 1)) begin
          state_d = CLR_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      CLR_DONE: begin
        state_d = CLR_IDLE;
      end
      default: begin
        state_d = CLR_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_we_c = (state_q == CLR_CLEAR);
  assign idle_c   = (state_q == CLR_IDLE);

endmodule

// File: rtl/multi_port_regfile.sv
// General-purpose register file: DEPTH x WIDTH storage, NUM_RD combinational read ports,
// one byte-masked falling-edge write port with optional bypass and hardwired zero entry.
module multi_port_regfile
  import cpu_regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multi_port_regfile_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = WIDTH / 8;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [WIDTH-1:0]        wr_merged;
  logic                    wr_live;
  logic                    wr_commit;
  logic                    clr_we_c;
  logic                    idle_c;
  logic [AW-1:0]           clr_ptr;
  logic [NUM_RD*WIDTH-1:0] rd_all;

  regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done),
    .clr_we_c (clr_we_c),
    .idle_c   (idle_c),
    .clr_ptr  (clr_ptr)
  );

  // Byte-merge of the incoming write over the currently stored word.
  always_comb begin
    wr_merged = mem[bus.wr_addr];
    for (int unsigned b = 0; b < BW; b++) begin
      if (bus.wr_be[b]) wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  // A write is only live while idle and with at least one byte enabled; entry 0 may be read-only.
  assign wr_live   = bus.wr_en && idle_c && (bus.wr_be != '0);
  assign wr_commit = wr_live && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we_c) begin
      mem[clr_ptr] <= '0;
    end else if (wr_commit) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  // Per-port read mux: zero entry first, then same-cycle bypass, then storage.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = bus.rd_addr[k*AW +: AW];

    always_comb begin
      if (ZERO_REG && (addr == '0)) begin
        data = '0;
      end else if (BYPASS && wr_live && (addr == bus.wr_addr)) begin
        data = wr_merged;
      end else begin
        data = mem[addr];
      end
    end

    assign rd_all[k*WIDTH +: WIDTH] = data;
  end

  assign bus.rd_data = rd_all;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Self-checking bench: two register files (bypass on/off) driven in lockstep against an array model.
module tb_multi_port_regfile;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        clr_req;

  int checks;
  int errors;
  logic [31:0] model [32];

  multi_port_regfile_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) if_a ();
  multi_port_regfile_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) if_b ();

  assign if_a.wr_en   = wr_en;
  assign if_a.wr_addr = wr_addr;
  assign if_a.wr_be   = wr_be;
  assign if_a.wr_data = wr_data;
  assign if_a.rd_addr = rd_addr;
  assign if_a.clr_req = clr_req;
  assign if_b.wr_en   = wr_en;
  assign if_b.wr_addr = wr_addr;
  assign if_b.wr_be   = wr_be;
  assign if_b.wr_data = wr_data;
  assign if_b.rd_addr = rd_addr;
  assign if_b.clr_req = clr_req;

  multi_port_regfile #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  multi_port_regfile #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Expected read value for the current bus state; byp selects the bypass-enabled instance.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && wr_en && (wr_be != 4'h0) && (ra == wr_addr)) return merge(model[wr_addr], wr_data, wr_be);
    return model[ra];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    @(posedge clk);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    @(negedge clk);
    if (a != 5'd0 && be != 4'h0) model[a] = merge(model[a], d, be);
    #1 wr_en = 1'b0;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) do_write(5'(i), 4'hF, 32'(i));
  endtask

  task automatic run_clear(output int bc, output int dc);
    @(posedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    bc = 0; dc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if_a.clr_busy) bc++;
      if (if_a.clr_done) dc++;
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    checks++;
    if (if_a.clr_busy !== 1'b0 || if_a.clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b required 0 0", if_a.clr_busy, if_a.clr_done);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)}; #1;
      checks++;
      if (if_a.rd_data !== 64'h0 || if_b.rd_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_read entry %0d a=%h b=%h required 0", i, if_a.rd_data, if_b.rd_data);
      end
    end
  endtask

  task automatic test_byte_write();
    do_write(5'd5, 4'hF, 32'hDEADBEEF);
    do_write(5'd5, 4'b0101, 32'h11223344);
    rd_addr = {5'd5, 5'd5}; #1;
    checks++;
    if (if_a.rd_data[31:0] !== 32'hDE22BE44 || if_a.rd_data[63:32] !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_write got %h required %h on both ports", if_a.rd_data, {2{32'hDE22BE44}});
    end
    checks++;
    if (if_b.rd_data[31:0] !== model[5]) begin
      errors++;
      $display("FAIL byte_write_model got %h required %h", if_b.rd_data[31:0], model[5]);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 4'hF, 32'h12345678);
    @(posedge clk);
    rd_addr = {5'd3, 5'd7};
    wr_en = 1'b1; wr_addr = 5'd7; wr_be = 4'hF; wr_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if (if_a.rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_on got %h required %h", if_a.rd_data[31:0], 32'hA5A5A5A5);
    end
    checks++;
    if (if_b.rd_data[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_off_before got %h required %h", if_b.rd_data[31:0], 32'h12345678);
    end
    @(negedge clk);
    model[7] = 32'hA5A5A5A5;
    #1 wr_en = 1'b0;
    checks++;
    if (if_b.rd_data[31:0] !== 32'hA5A5A5A5 || if_a.rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_after got a=%h b=%h required %h", if_a.rd_data[31:0], if_b.rd_data[31:0], 32'hA5A5A5A5);
    end
    // An all-zero byte mask must not bypass.
    @(posedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_be = 4'h0; wr_data = 32'h0F0F0F0F;
    #1;
    checks++;
    if (if_a.rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_be0 got %h required %h", if_a.rd_data[31:0], 32'hA5A5A5A5);
    end
    @(negedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic test_zero_reg();
    @(posedge clk);
    rd_addr = {5'd0, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd0; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (if_a.rd_data !== 64'h0 || if_b.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL zero_bypass got a=%h b=%h required 0", if_a.rd_data, if_b.rd_data);
    end
    @(negedge clk);
    #1 wr_en = 1'b0;
    checks++;
    if (if_a.rd_data !== 64'h0 || if_b.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL zero_stored got a=%h b=%h required 0", if_a.rd_data, if_b.rd_data);
    end
  endtask

  task automatic test_random();
    logic [4:0] ra0, ra1;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      ra0 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rd_addr = {ra1, ra0};
      #1;
      checks++;
      if (if_a.rd_data !== {exp_rd(ra1, 1'b1), exp_rd(ra0, 1'b1)}) begin
        errors++;
        $display("FAIL random_bypass n=%0d got %h required %h", n, if_a.rd_data, {exp_rd(ra1, 1'b1), exp_rd(ra0, 1'b1)});
      end
      checks++;
      if (if_b.rd_data !== {exp_rd(ra1, 1'b0), exp_rd(ra0, 1'b0)}) begin
        errors++;
        $display("FAIL random_plain n=%0d got %h required %h", n, if_b.rd_data, {exp_rd(ra1, 1'b0), exp_rd(ra0, 1'b0)});
      end
      @(negedge clk);
      if (wr_en && wr_be != 4'h0 && wr_addr != 5'd0) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
    end
    #1 wr_en = 1'b0;
  endtask

  task automatic test_clear();
    int c, dc;
    bit done_ok;
    fill_index();
    rd_addr = {5'd2, 5'd31};
    @(posedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    c = 0; dc = 0; done_ok = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      wr_en = 1'b0; rd_addr = {5'd2, 5'd31};
      clr_req = (cyc == 10);
      #1;
      if (if_a.clr_busy) begin
        c++;
        checks++;
        if (if_a.rd_data[31:0] !== 32'd31 || if_a.rd_data[63:32] !== ((c - 1 > 2) ? 32'd0 : 32'd2)) begin
          errors++;
          $display("FAIL clear_progress busy_cycle %0d got %h required %h", c, if_a.rd_data,
                   {((c - 1 > 2) ? 32'd0 : 32'd2), 32'd31});
        end
        if (c == 5) begin
          wr_en = 1'b1; wr_addr = 5'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF; rd_addr[4:0] = 5'd3;
          #1;
          checks++;
          if (if_a.rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL clear_write_bypass got %h required 0", if_a.rd_data[31:0]);
          end
        end
      end
      if (if_a.clr_done) begin
        dc++;
        if (c == 32 && !if_a.clr_busy) done_ok = 1'b1;
      end
    end
    clr_req = 1'b0;
    checks++;
    if (c != 32 || dc != 1 || !done_ok) begin
      errors++;
      $display("FAIL clear_timing busy_cycles=%0d done_pulses=%0d done_after_busy=%0b required 32 1 1", c, dc, done_ok);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)}; #1;
      checks++;
      if (if_a.rd_data !== 64'h0) begin
        errors++;
        $display("FAIL clear_result entry %0d got %h required 0", i, if_a.rd_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int c, bc, dc;
    bit bad;
    fill_index();
    @(posedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    c = 0;
    for (int i = 0; i < 20 && c < 10; i++) begin
      @(posedge clk); #1;
      if (if_a.clr_busy) c++;
    end
    checks++;
    if (c != 10) begin
      errors++;
      $display("FAIL mid_clear_start busy_cycles=%0d required 10", c);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    checks++;
    if (if_a.clr_busy !== 1'b0 || if_a.clr_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_status busy=%b done=%b required 0 0", if_a.clr_busy, if_a.clr_done);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)}; #1;
      checks++;
      if (if_a.rd_data !== 64'h0) begin
        errors++;
        $display("FAIL mid_clear_read entry %0d got %h required 0", i, if_a.rd_data);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if_a.clr_done !== 1'b0 || if_a.clr_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_clear_no_done observed busy or done after reset, required neither");
    end
    do_write(5'd9, 4'hF, 32'd99);
    run_clear(bc, dc);
    checks++;
    if (bc != 32 || dc != 1) begin
      errors++;
      $display("FAIL reclear_timing busy_cycles=%0d done_pulses=%0d required 32 1", bc, dc);
    end
    rd_addr = {5'd9, 5'd9}; #1;
    checks++;
    if (if_a.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reclear_entry9 got %h required 0", if_a.rd_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_byte_write();
    test_bypass();
    test_zero_reg();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
